// File: rtl/and16_pkg.sv
// Shared definitions for the bit-serial AND engine.
// Provides the default operand width, the matching index width and the
// engine state encoding.
package and16_pkg;

  parameter int unsigned WIDTH = 16;
  parameter int unsigned IDXW  = $clog2(WIDTH);

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } and16_state_t;

endpackage

// File: rtl/and16_serial.sv
// Bit-serial bitwise-AND engine.
// Accepts an operand pair on a valid/ready handshake. It then streams
// a[i] & b[i] one bit per accepted beat, LSB first, and reassembles the
// result word for parallel readback.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_ni       synchronous active-low reset
//   a_i, b_i     operands, sampled on the input handshake
//   in_valid_i   producer offers an operand pair
//   in_ready_o   engine is idle and can accept a pair
//   bit_out_o    current result bit (0 when bit_valid_o is low)
//   bit_idx_o    index of bit_out_o (0 when bit_valid_o is low)
//   bit_valid_o  bit_out_o/bit_idx_o are valid
//   bit_ready_i  consumer takes the current bit
//   out_o        assembled result word, held until the next accept
//   out_valid_o  one-cycle pulse when out_o is complete
module and16_serial
  import and16_pkg::*;
#(
  parameter int unsigned Width = WIDTH,
  localparam int unsigned IdxW = $clog2(Width)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic             bit_out_o,
  output logic [IdxW-1:0]  bit_idx_o,
  output logic             bit_valid_o,
  input  logic             bit_ready_i,
  output logic [Width-1:0] out_o,
  output logic             out_valid_o
);

  localparam logic [IdxW-1:0] LastIdx = IdxW'(Width - 1);

  and16_state_t     state_q;
  logic [Width-1:0] a_q;
  logic [Width-1:0] b_q;
  logic [Width-1:0] out_q;
  logic [IdxW-1:0]  idx_q;
  logic             in_ready_q;
  logic             bit_valid_q;
  logic             out_valid_q;
  logic             bit_sel;

  // Bit select is purely from registered state, so no input reaches an output.
  assign bit_sel = a_q[idx_q] & b_q[idx_q];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      out_q       <= '0;
      idx_q       <= '0;
      in_ready_q  <= 1'b1;
      bit_valid_q <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid_i) begin
            a_q         <= a_i;
            b_q         <= b_i;
            idx_q       <= '0;
            out_q       <= '0;
            state_q     <= StShift;
            in_ready_q  <= 1'b0;
            bit_valid_q <= 1'b1;
          end
        end
        StShift: begin
          if (bit_ready_i) begin
            out_q[idx_q] <= bit_sel;
            if (idx_q == LastIdx) begin
              state_q     <= StDone;
              bit_valid_q <= 1'b0;
              out_valid_q <= 1'b1;
            end else begin
              idx_q <= idx_q + IdxW'(1);
            end
          end
        end
        StDone: begin
          state_q     <= StIdle;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
        default: begin
          state_q     <= StIdle;
          in_ready_q  <= 1'b1;
          bit_valid_q <= 1'b0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready_o  = in_ready_q;
  assign bit_valid_o = bit_valid_q;
  assign bit_out_o   = bit_valid_q & bit_sel;
  assign bit_idx_o   = bit_valid_q ? idx_q : '0;
  assign out_o       = out_q;
  assign out_valid_o = out_valid_q;

endmodule

// File: tb/tb_and16_serial.sv
module tb_and16_serial;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] a;
  logic [15:0] b;
  logic        in_valid;
  logic        in_ready;
  logic        bit_out;
  logic [3:0]  bit_idx;
  logic        bit_valid;
  logic        bit_ready;
  logic [15:0] out_w;
  logic        out_valid;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  and16_serial dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .a_i        (a),
    .b_i        (b),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .bit_out_o  (bit_out),
    .bit_idx_o  (bit_idx),
    .bit_valid_o(bit_valid),
    .bit_ready_i(bit_ready),
    .out_o      (out_w),
    .out_valid_o(out_valid)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Send one word and follow it through to in_ready returning. Expected bits
  // come from av & bv directly; latency is 17 cycles plus one per stall.
  task automatic run_word(input logic [15:0] av, input logic [15:0] bv,
                          input int stall_idx, input int stall_len,
                          input bit rand_stall, input bit junk, output int ov_cyc);
    logic [15:0] exp_w;
    int i;
    int stalls;
    int st_cnt;
    int guard;
    int t0;
    exp_w  = av & bv;
    i      = 0;
    stalls = 0;
    st_cnt = 0;
    guard  = 0;
    ov_cyc = -1;
    check_eq("in_ready_pre", in_ready, 1);
    a = av;
    b = bv;
    in_valid = 1'b1;
    t0 = cyc;
    step();
    if (junk) begin
      a = 16'($urandom);
      b = 16'($urandom);
    end else begin
      in_valid = 1'b0;
    end
    while (i < 16) begin
      guard++;
      if (guard > 400) begin
        check_eq("shift_timeout", 0, 1);
        return;
      end
      check_eq("bit_valid", bit_valid, 1);
      check_eq("bit_idx", bit_idx, i);
      check_eq("bit_out", bit_out, exp_w[i]);
      check_eq("in_ready_busy", in_ready, 0);
      check_eq("out_valid_early", out_valid, 0);
      if (i == stall_idx && st_cnt < stall_len) begin
        bit_ready = 1'b0;
        st_cnt++;
      end else if (rand_stall && $urandom_range(0, 3) == 0) begin
        bit_ready = 1'b0;
      end else begin
        bit_ready = 1'b1;
      end
      if (!bit_ready) stalls++;
      if (junk) begin
        a = 16'($urandom);
        b = 16'($urandom);
      end
      step();
      if (bit_ready) i++;
    end
    in_valid  = 1'b0;
    bit_ready = 1'b1;
    check_eq("out_valid", out_valid, 1);
    check_eq("out_word", out_w, exp_w);
    check_eq("latency", cyc - t0, 17 + stalls);
    check_eq("bit_valid_done", bit_valid, 0);
    check_eq("bit_out_done", bit_out, 0);
    check_eq("bit_idx_done", bit_idx, 0);
    check_eq("in_ready_done", in_ready, 0);
    ov_cyc = cyc;
    step();
    check_eq("in_ready_back", in_ready, 1);
    check_eq("out_valid_pulse", out_valid, 0);
    check_eq("out_hold", out_w, exp_w);
  endtask

  initial begin
    int ov1;
    int ov2;
    int tstart;
    logic seen_ov;

    rst_n = 1'b0;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    bit_ready = 1'b0;
    step();
    step();
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_bit_valid", bit_valid, 0);
    check_eq("rst_bit_out", bit_out, 0);
    check_eq("rst_bit_idx", bit_idx, 0);
    check_eq("rst_out", out_w, 0);
    check_eq("rst_out_valid", out_valid, 0);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      check_eq("idle_bit_valid", bit_valid, 0);
      check_eq("idle_in_ready", in_ready, 1);
    end

    run_word(16'h00FF, 16'hFFFF, -1, 0, 1'b0, 1'b0, ov1);
    run_word(16'hA5A5, 16'h0FF0, 3, 3, 1'b0, 1'b0, ov1);
    run_word(16'hC3C3, 16'h7E7E, -1, 0, 1'b0, 1'b1, ov1);
    run_word(16'h5555, 16'hFFFF, -1, 0, 1'b0, 1'b0, ov1);

    // Reset in the middle of a word: no completion, everything cleared.
    a = 16'hFFFF;
    b = 16'hFFFF;
    in_valid = 1'b1;
    bit_ready = 1'b1;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 9; k++) step();
    check_eq("mid_idx", bit_idx, 9);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check_eq("abort_in_ready", in_ready, 1);
    check_eq("abort_bit_valid", bit_valid, 0);
    check_eq("abort_out", out_w, 0);
    check_eq("abort_out_valid", out_valid, 0);
    seen_ov = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      seen_ov = seen_ov | out_valid;
    end
    check_eq("abort_no_ov", seen_ov, 0);
    run_word(16'h1234, 16'hFF00, -1, 0, 1'b0, 1'b0, ov1);

    // Reset wins over a simultaneous input offer.
    rst_n = 1'b0;
    in_valid = 1'b1;
    a = 16'hFFFF;
    b = 16'hFFFF;
    step();
    rst_n = 1'b1;
    in_valid = 1'b0;
    check_eq("rst_vs_valid_ready", in_ready, 1);
    check_eq("rst_vs_valid_bv", bit_valid, 0);
    step();
    check_eq("rst_vs_valid_bv2", bit_valid, 0);

    // Back-to-back words.
    tstart = cyc;
    run_word(16'hFFFF, 16'hFFFF, -1, 0, 1'b0, 1'b0, ov1);
    run_word(16'h0000, 16'hFFFF, -1, 0, 1'b0, 1'b0, ov2);
    check_eq("b2b_ov1", ov1 - tstart, 17);
    check_eq("b2b_ov2", ov2 - tstart, 35);

    for (int k = 0; k < 20; k++) begin
      run_word(16'($urandom), 16'($urandom), -1, 0, 1'b1, k[0], ov1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
